// File: rtl/stage1_match_ctrl.sv
// stage1_match_ctrl
//   Sequencer for the stage-1 compression matching datapath. It accepts one
//   block of i_block_len beats from a valid/ready source and clears the
//   dictionary at block start. Each accepted beat is held on o_word until
//   stage 2 consumes the match results. Each consumed beat writes the
//   dictionary exactly once. Block completion is flagged with a one-cycle
//   o_done pulse.
//
// Ports
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_start, i_block_len block start pulse and length (sampled in IDLE only)
//   i_valid, o_ready     source beat handshake, i_data is the source beat
//   o_word               registered beat presented to the matching stage
//   o_dict_wr_en         dictionary write enable (one per consumed beat)
//   o_dict_clear         one-cycle synchronous dictionary clear
//   i_dict_full          dictionary full status (informational only)
//   o_valid, i_ready     result handshake towards stage 2, o_last marks final beat
//   o_busy, o_done       activity flag and block-complete pulse
//   o_beat_count         beats consumed downstream in the current block
//
// state | meaning
// IDLE  | waiting for i_start
// CLEAR | dictionary clear cycle, beat counter reset
// RUN   | accepting beats until the final beat is taken
// DRAIN | final beat held until stage 2 consumes it
// DONE  | one-cycle completion pulse
module stage1_match_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [LEN_W-1:0]      i_block_len,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_dict_wr_en,
    output logic                  o_dict_clear,
    input  logic                  i_dict_full,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_W-1:0]      o_beat_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic             transfer;
    logic             consume;

    // Dictionary fullness is owned by the matching stage; it is deliberately
    // not part of any handshake so FIFO wrap never stalls the block.
    logic unused_full;
    assign unused_full = i_dict_full;

    always_comb begin
        state_next   = state;
        o_ready      = 1'b0;
        o_busy       = (state != IDLE);
        consume      = o_valid && i_ready;
        o_dict_wr_en = consume;

        if (state == RUN)
            o_ready = (remaining != '0) && (!o_valid || i_ready);
        transfer = i_valid && o_ready;

        case (state)
            IDLE:    if (i_start) state_next = CLEAR;
            CLEAR:   state_next = (remaining != '0) ? RUN : DONE;
            RUN:     if (transfer && remaining == LEN_W'(1)) state_next = DRAIN;
            DRAIN:   if (consume) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            remaining    <= '0;
            o_word       <= '0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_done       <= 1'b0;
            o_dict_clear <= 1'b0;
            o_beat_count <= '0;
        end else begin
            state        <= state_next;
            // Registered so they are high exactly while in CLEAR / DONE.
            o_dict_clear <= (state_next == CLEAR);
            o_done       <= (state_next == DONE);

            if (state == IDLE && i_start)
                remaining <= i_block_len;

            if (transfer) begin
                o_word    <= i_data;
                o_valid   <= 1'b1;
                remaining <= remaining - LEN_W'(1);
                o_last    <= (remaining == LEN_W'(1));
            end else if (consume) begin
                o_valid <= 1'b0;
            end

            if (state == CLEAR)
                o_beat_count <= '0;
            else if (consume && o_beat_count != '1)
                o_beat_count <= o_beat_count + LEN_W'(1);
        end
    end

endmodule
